// File: rtl/sdr_port_arbiter.sv
// rtl/sdr_port_arbiter.sv - round-robin arbiter sharing the 16-bit SDRAM Avalon-MM master port
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_read/req_write         per-requester command strobes (requester i = bit i)
//   req_address                32 bits per requester, requester i at [32*i+31:32*i]
//   req_writedata              16 bits per requester
//   req_byteenable             2 bits per requester
//   req_waitrequest            per-requester stall
//   req_readdata               downstream read data, broadcast to every requester
//   req_readdatavalid          one-hot valid to the requester that owns the returning read
//   avm_m0_*                   shared downstream Avalon-MM master port
//   err_orphan                 sticky: read data returned with no outstanding read recorded
module sdr_port_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_HOLD   = 8,
    parameter int PEND_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_read,
    input  logic [NREQ-1:0]      req_write,
    input  logic [32*NREQ-1:0]   req_address,
    input  logic [16*NREQ-1:0]   req_writedata,
    input  logic [2*NREQ-1:0]    req_byteenable,
    output logic [NREQ-1:0]      req_waitrequest,
    output logic [15:0]          req_readdata,
    output logic [NREQ-1:0]      req_readdatavalid,
    output logic                 avm_m0_read,
    output logic                 avm_m0_write,
    output logic [31:0]          avm_m0_address,
    output logic [15:0]          avm_m0_writedata,
    output logic [1:0]           avm_m0_byteenable,
    input  logic                 avm_m0_waitrequest,
    input  logic [15:0]          avm_m0_readdata,
    input  logic                 avm_m0_readdatavalid,
    output logic                 err_orphan
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int PW  = $clog2(PEND_DEPTH);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_GRANT  = 1'b1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(PEND_DEPTH);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [PW:0]    count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           err_q, err_d;
    logic [IDW-1:0] tag_mem_q [PEND_DEPTH];

    logic [NREQ-1:0] req_any;
    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  pick;
    int              pick_best;
    int              pick_dist;
    logic            g_read, g_write;
    logic [31:0]     g_addr;
    logic [15:0]     g_wd;
    logic [1:0]      g_be;
    logic            in_grant;
    logic            others_req;
    logic            fifo_full, fifo_empty;
    logic            pop, push, blocked, accept;
    logic [IDW-1:0]  head_id;

    assign req_any = req_read | req_write;

    // Next owner is the requesting index closest after last_id, wrapping.
    // dist is 0 for last_id+1 and NREQ-1 for last_id itself.
    always_comb begin
        pick      = last_q;
        pick_best = NREQ;
        pick_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            pick_dist = (i + NREQ - 1 - int'(last_q)) % NREQ;
            if (req_any[i] && pick_dist < pick_best) begin
                pick_best = pick_dist;
                pick      = IDW'(i);
            end
        end
    end

    always_comb begin
        g_read   = 1'b0;
        g_write  = 1'b0;
        g_addr   = '0;
        g_wd     = '0;
        g_be     = '0;
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                grant_oh[i] = 1'b1;
                g_read      = req_read[i];
                g_write     = req_write[i];
                g_addr      = req_address[32*i +: 32];
                g_wd        = req_writedata[16*i +: 16];
                g_be        = req_byteenable[2*i +: 2];
            end
        end
    end

    assign in_grant   = (state_q == ST_GRANT);
    assign others_req = |(req_any & ~grant_oh);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign head_id    = tag_mem_q[rd_ptr_q];

    // A returning read in the same cycle frees the slot the stalled read needs.
    assign pop     = avm_m0_readdatavalid & ~fifo_empty;
    assign blocked = g_read & fifo_full & ~pop;

    // Read wins when a requester raises both strobes; the write is dropped.
    assign avm_m0_read       = in_grant & g_read & ~blocked;
    assign avm_m0_write      = in_grant & g_write & ~g_read;
    assign avm_m0_address    = in_grant ? g_addr : 32'h0;
    assign avm_m0_writedata  = in_grant ? g_wd : 16'h0;
    assign avm_m0_byteenable = in_grant ? g_be : 2'b00;

    assign accept = (avm_m0_read | avm_m0_write) & ~avm_m0_waitrequest;
    assign push   = avm_m0_read & ~avm_m0_waitrequest;

    always_comb begin
        req_waitrequest = '1;
        if (in_grant) begin
            req_waitrequest = ~grant_oh | {NREQ{blocked | avm_m0_waitrequest}};
        end
    end

    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_readdatavalid[i] = pop & (head_id == IDW'(i));
        end
    end

    assign req_readdata = avm_m0_readdata;
    assign err_orphan   = err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_any) begin
                    grant_d = pick;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            default: begin
                if (accept) begin
                    last_d = grant_q;
                    if (hold_q == HOLD_LAST && others_req) begin
                        state_d = ST_IDLE;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else if (!g_read && !g_write) begin
                    state_d = ST_IDLE;
                end
                // A stalled command keeps the grant: nothing changes here.
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
        err_d = err_q | (avm_m0_readdatavalid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= IDW'(NREQ - 1);
            hold_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset: count/pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_q;
        end
    end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb/tb_sdr_port_arbiter.sv - randomized self-checking bench for sdr_port_arbiter
module tb_sdr_port_arbiter;

    localparam int NREQ       = 2;
    localparam int MAX_HOLD   = 8;
    localparam int PEND_DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_read;
    logic [NREQ-1:0]     req_write;
    logic [32*NREQ-1:0]  req_address;
    logic [16*NREQ-1:0]  req_writedata;
    logic [2*NREQ-1:0]   req_byteenable;
    logic [NREQ-1:0]     req_waitrequest;
    logic [15:0]         req_readdata;
    logic [NREQ-1:0]     req_readdatavalid;
    logic                avm_m0_read;
    logic                avm_m0_write;
    logic [31:0]         avm_m0_address;
    logic [15:0]         avm_m0_writedata;
    logic [1:0]          avm_m0_byteenable;
    logic                avm_m0_waitrequest;
    logic [15:0]         avm_m0_readdata;
    logic                avm_m0_readdatavalid;
    logic                err_orphan;

    always #5 clk = ~clk;

    sdr_port_arbiter #(
        .NREQ       (NREQ),
        .MAX_HOLD   (MAX_HOLD),
        .PEND_DEPTH (PEND_DEPTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_address          (req_address),
        .req_writedata        (req_writedata),
        .req_byteenable       (req_byteenable),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .err_orphan           (err_orphan)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side command registers (held until accepted).
    bit          has_cmd [NREQ];
    bit          c_rd    [NREQ];
    bit          c_wr    [NREQ];
    logic [31:0] c_addr  [NREQ];
    logic [15:0] c_wd    [NREQ];
    logic [1:0]  c_be    [NREQ];

    // Outstanding reads in acceptance order: who owns each and what data it should carry.
    typedef struct { int owner; logic [15:0] data; } rd_rec_t;
    rd_rec_t pend_q[$];

    // Downstream memory model: accepted reads waiting to be returned.
    typedef struct { int due; logic [15:0] data; } sl_rec_t;
    sl_rec_t sl_q[$];

    int  m_owner;   // -1 when nobody holds the port
    int  m_last;
    int  m_hold;    // commands accepted in the current grant, capped at MAX_HOLD-1
    bit  m_err;
    int  cyc = 0;
    int  stalls_seen = 0;
    int  p_req, p_wait, p_rdv, lat_max;
    logic [NREQ-1:0] req_mask;
    bit  force_orphan = 0;

    function automatic logic [15:0] resp_data(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (pend_q.size() > 0) || (sl_q.size() > 0);
        for (int i = 0; i < NREQ; i++) b = b | has_cmd[i];
        return b;
    endfunction

    task automatic run_cycle();
        logic [NREQ-1:0] exp_wait;
        logic [NREQ-1:0] exp_rdv;
        bit exp_rd, exp_wr, stalled, popping, accepted, g_rd, g_wr, others;
        int g;
        // Requesters raise new commands.
        for (int i = 0; i < NREQ; i++) begin
            if (!has_cmd[i] && req_mask[i] && $urandom_range(99) < p_req) begin
                int r;
                r = $urandom_range(3);
                has_cmd[i] = 1;
                c_rd[i]    = (r != 2);
                c_wr[i]    = (r >= 2);
                c_addr[i]  = $urandom;
                c_wd[i]    = 16'($urandom);
                c_be[i]    = 2'($urandom);
            end
            req_read[i]                 = has_cmd[i] & c_rd[i];
            req_write[i]                = has_cmd[i] & c_wr[i];
            req_address[32*i +: 32]     = c_addr[i];
            req_writedata[16*i +: 16]   = c_wd[i];
            req_byteenable[2*i +: 2]    = c_be[i];
        end
        // Downstream memory behaviour.
        avm_m0_waitrequest = ($urandom_range(99) < p_wait);
        if (force_orphan) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = 16'($urandom);
        end else if (sl_q.size() > 0 && sl_q[0].due <= cyc && $urandom_range(99) < p_rdv) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = sl_q[0].data;
            void'(sl_q.pop_front());
        end else begin
            avm_m0_readdatavalid = 1'b0;
            avm_m0_readdata      = 16'($urandom);
        end
        #1;
        // Expected behaviour for this cycle.
        exp_rd = 0; exp_wr = 0; stalled = 0; g_rd = 0; g_wr = 0;
        exp_wait = {NREQ{1'b1}};
        exp_rdv  = '0;
        g = m_owner;
        popping = avm_m0_readdatavalid && (pend_q.size() > 0);
        if (g >= 0) begin
            g_rd    = req_read[g];
            g_wr    = req_write[g];
            stalled = g_rd && (pend_q.size() == PEND_DEPTH) && !popping;
            exp_rd  = g_rd && !stalled;
            exp_wr  = g_wr && !g_rd;
            exp_wait[g] = stalled || avm_m0_waitrequest;
        end
        chk("avm_read", 64'(avm_m0_read), 64'(exp_rd));
        chk("avm_write", 64'(avm_m0_write), 64'(exp_wr));
        chk("req_wait", 64'(req_waitrequest), 64'(exp_wait));
        if (exp_rd || exp_wr) begin
            chk("avm_addr", 64'(avm_m0_address), 64'(c_addr[g]));
            chk("avm_be", 64'(avm_m0_byteenable), 64'(c_be[g]));
        end
        if (exp_wr) chk("avm_wdata", 64'(avm_m0_writedata), 64'(c_wd[g]));
        if (popping) begin
            exp_rdv[pend_q[0].owner] = 1'b1;
            chk("rd_data", 64'(req_readdata), 64'(pend_q[0].data));
        end
        chk("rd_bcast", 64'(req_readdata), 64'(avm_m0_readdata));
        chk("rd_valid", 64'(req_readdatavalid), 64'(exp_rdv));
        chk("err_orphan", 64'(err_orphan), 64'(m_err));
        // Advance the reference.
        accepted = (exp_rd || exp_wr) && !avm_m0_waitrequest;
        if (stalled) stalls_seen++;
        if (avm_m0_readdatavalid && pend_q.size() == 0) m_err = 1;
        if (popping) void'(pend_q.pop_front());
        if (accepted) begin
            if (exp_rd) begin
                rd_rec_t rr;
                rr.owner = g;
                rr.data  = resp_data(c_addr[g]);
                pend_q.push_back(rr);
            end
            has_cmd[g] = 0;
        end
        if (avm_m0_read && !avm_m0_waitrequest) begin
            sl_rec_t sr;
            sr.due  = cyc + 1 + $urandom_range(lat_max);
            sr.data = resp_data(avm_m0_address);
            sl_q.push_back(sr);
        end
        others = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (i != g && (req_read[i] || req_write[i])) others = 1;
        end
        if (g >= 0) begin
            if (accepted) begin
                m_last = g;
                if (m_hold == MAX_HOLD - 1 && others) m_owner = -1;
                else if (m_hold < MAX_HOLD - 1) m_hold++;
            end else if (!g_rd && !g_wr) begin
                m_owner = -1;
            end
        end else if ((req_read | req_write) != '0) begin
            for (int k = NREQ; k >= 1; k--) begin
                if (req_read[(m_last + k) % NREQ] || req_write[(m_last + k) % NREQ])
                    m_owner = (m_last + k) % NREQ;
            end
            m_hold = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_read = '0;
        req_write = '0;
        avm_m0_waitrequest = 1'b0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata = 16'h0;
        for (int i = 0; i < NREQ; i++) has_cmd[i] = 0;
        @(posedge clk);
        #1;
        chk("rst_wait", 64'(req_waitrequest), 64'({NREQ{1'b1}}));
        chk("rst_read", 64'(avm_m0_read), 64'(0));
        chk("rst_write", 64'(avm_m0_write), 64'(0));
        chk("rst_addr", 64'(avm_m0_address), 64'(0));
        chk("rst_valid", 64'(req_readdatavalid), 64'(0));
        chk("rst_err", 64'(err_orphan), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_owner = -1;
        m_last  = NREQ - 1;
        m_hold  = 0;
        m_err   = 0;
        pend_q.delete();
    endtask

    task automatic run_phase(input int n, input int pr, input int pw, input int pv,
                             input int lat, input logic [NREQ-1:0] mask);
        p_req = pr; p_wait = pw; p_rdv = pv; lat_max = lat; req_mask = mask;
        for (int c = 0; c < n; c++) run_cycle();
    endtask

    task automatic drain(input string tag);
        p_req = 0; p_wait = 0; p_rdv = 100; lat_max = 1;
        for (int n = 0; n < 400 && busy(); n++) run_cycle();
        chk(tag, 64'(busy()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            c_rd[i] = 0; c_wr[i] = 0; c_addr[i] = $urandom; c_wd[i] = 16'($urandom); c_be[i] = 2'($urandom);
        end
        req_address = '0; req_writedata = '0; req_byteenable = '0;
        p_req = 0; p_wait = 0; p_rdv = 100; lat_max = 3; req_mask = '1;
        do_reset();

        run_phase(200, 100, 0, 100, 3, 2'b01);  // lone requester 0, back-to-back
        run_phase(300, 100, 0, 100, 3, 2'b11);  // both saturating: alternating bursts
        run_phase(300, 90, 15, 8, 6, 2'b11);    // slow returns: tag FIFO fills and blocks
        run_phase(400, 60, 40, 60, 4, 2'b11);   // mixed traffic with downstream stalls
        run_phase(200, 50, 70, 50, 2, 2'b10);   // lone requester 1, heavy stalls
        drain("drain_main");
        chk("stall_seen", 64'(stalls_seen > 0), 64'(1));

        // Read data with nothing outstanding.
        p_req = 0; p_rdv = 0;
        force_orphan = 1;
        run_cycle();
        force_orphan = 0;
        for (int n = 0; n < 3; n++) run_cycle();
        chk("orphan_sticky", 64'(err_orphan), 64'(1));

        // Reset while reads are in flight; their late returns are orphans.
        do_reset();
        run_phase(30, 100, 0, 0, 2, 2'b11);
        do_reset();
        drain("drain_after_reset");
        chk("orphan_after_reset", 64'(err_orphan), 64'(1));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_port_arbiter.md
# sdr_port_arbiter

Round-robin arbiter sharing the single 16-bit Avalon-MM SDRAM master port of the ray tracer between NREQ requester masters (e.g. the scene/result transfer engine and the triangle intersector). Replaces OR-combining of requester buses with explicit grant, per-requester waitrequest, and tag-tracked routing of pipelined read responses. Sits between the requester masters and the top-level avm_m0 port.

## Interface
- NREQ, 2: number of requesters (1..8); requester 0 is index 0 of every packed vector.
- MAX_HOLD, 8: maximum consecutive accepted commands per grant while another requester waits (≥1).
- PEND_DEPTH, 8: maximum outstanding reads; tag FIFO depth (power of 2, ≥2).

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_read  in  NREQ  per-requester read command
- req_write  in  NREQ  per-requester write command
- req_address  in  32*NREQ  byte address, requester i at [32*i+31:32*i]
- req_writedata  in  16*NREQ  write data
- req_byteenable  in  2*NREQ  byte enables
- req_waitrequest  out  NREQ  per-requester stall
- req_readdata  out  16  read data, broadcast to all requesters
- req_readdatavalid  out  NREQ  read data valid, one-hot, to owning requester only
- avm_m0_read / avm_m0_write  out  1  downstream command
- avm_m0_address  out  32  downstream address
- avm_m0_writedata  out  16  downstream write data
- avm_m0_byteenable  out  2  downstream byte enables
- avm_m0_waitrequest  in  1  downstream stall
- avm_m0_readdata  in  16  downstream read data
- avm_m0_readdatavalid  in  1  downstream read data valid
- err_orphan  out  1  sticky: readdatavalid received with empty tag FIFO

## Operation
- FSM states IDLE, GRANT; registers grant_id, last_id, hold_cnt, tag FIFO (count, rd/wr pointers), err_orphan.
- IDLE: downstream read/write 0, all req_waitrequest 1. If any requester has read|write, grant_id ← first requesting index after last_id (wrapping, modulo NREQ), hold_cnt ← 0, go GRANT.
- GRANT: downstream address/writedata/byteenable/read/write muxed combinationally from grant_id; non-grantees see waitrequest 1; grantee sees avm_m0_waitrequest, or 1 when blocked.
- Read and write both high: read forwarded, write masked.
- Read blocking: grantee read while FIFO count == PEND_DEPTH → downstream read forced 0, grantee waitrequest 1 until a pop frees a slot.
- Acceptance = downstream (read|write) & !avm_m0_waitrequest. Accepted read pushes grant_id into tag FIFO.
- On acceptance: last_id ← grant_id; if hold_cnt == MAX_HOLD-1 and another requester has read|write → IDLE; else stay GRANT, hold_cnt ← hold_cnt+1 saturating at MAX_HOLD-1.
- In GRANT with grantee read and write both 0 → IDLE next cycle.
- Response: avm_m0_readdatavalid pops FIFO head; req_readdatavalid[head] = 1 same cycle; req_readdata = avm_m0_readdata always.
- readdatavalid with FIFO empty: no pop, no requester valid, err_orphan ← 1 (cleared only by reset).
- Simultaneous push and pop: count unchanged; pop at count == PEND_DEPTH unblocks a push in the same cycle.

## Timing
- Reset: state IDLE, last_id = NREQ-1 (requester 0 wins first), hold_cnt 0, FIFO empty, err_orphan 0; all downstream outputs 0; req_waitrequest all 1; req_readdatavalid 0.
- Reset mid-transfer discards FIFO; later readdatavalids set err_orphan.
- Grant latency: request first seen in IDLE cycle n → command downstream in cycle n+1 (1-cycle arbitration bubble per grant).
- Within a grant, back-to-back commands accepted every cycle when downstream waitrequest low.
- Read response routing is combinational: zero added latency from avm_m0_readdatavalid to req_readdatavalid.
- Requesters must hold command stable while their waitrequest is 1 (Avalon rule); a grant never changes while a command is stalled.

## Test plan
- Single requester 0 issues 7 reads, downstream latency 3, waitrequest 0 → 7 commands on consecutive cycles after 1-cycle bubble; 7 valids to requester 0 only, data in order.
- Both requesters read continuously, MAX_HOLD=8 → alternating bursts of 8 accepts, grant 0 first, 1-cycle IDLE bubble between bursts.
- Req 0 reads 4 then req 1 writes 3 while req 0 reads pending → write accepted; returning 4 valids routed to req 0, none to req 1.
- PEND_DEPTH=8, downstream withholds readdatavalid → 9th read stalled (waitrequest 1, avm_m0_read 0); first valid releases it same cycle.
- Downstream waitrequest held 5 cycles mid-burst → grantee waitrequest 1, address stable, no grant change despite competing request.
- readdatavalid pulse with empty FIFO → no req_readdatavalid, err_orphan 1 until reset.
